word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter LETTER_W, default 8, meaning bits per letter code.
REQ-002 SHALL have parameter MAX_LEN, default 15, meaning letter slots per word; word width W = LETTER_W*MAX_LEN = 120.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, meaning cycles to wait for DTW finish.
REQ-004 SHALL have port i_WP_clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port i_WP_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_WP_letter, input, LETTER_W, classified letter code; 0 means blank.
REQ-007 SHALL have port i_WP_letter_valid, input, 1, qualifies i_WP_letter for one cycle.
REQ-008 SHALL have port i_WP_word_end, input, 1, one-cycle end-of-word pulse.
REQ-009 SHALL have port o_WP_ready, output, 1, high only in S_COLLECT.
REQ-010 SHALL have port o_WP_dtw_start, output, 1, start pulse to the DTW matcher.
REQ-011 SHALL have port o_WP_dtw_word, output, W, packed query word to DTW.
REQ-012 SHALL have port i_WP_dtw_finish, input, 1, DTW done strobe.
REQ-013 SHALL have port i_WP_dtw_result, input, W, corrected word from DTW.
REQ-014 SHALL have port o_WP_word, output, W, final word; o_WP_word_valid, output, 1; i_WP_word_ack, input, 1.
REQ-015 SHALL have port o_WP_len, output, 4, letters packed; o_WP_overflow, output, 1, sticky drop flag; o_WP_timeout, output, 1; o_WP_state, output, 2.

Function
REQ-016 SHALL implement states S_COLLECT=0, S_START=1, S_WAIT=2, S_DONE=3, reported on o_WP_state.
REQ-017 SHALL in S_COLLECT append an accepted letter at bits [LETTER_W*len +: LETTER_W], first letter in LSBs, then increment len.
REQ-018 SHALL ignore letter code 0 and any letter_valid outside S_COLLECT.
REQ-019 SHALL, when len==MAX_LEN, drop further letters and set o_WP_overflow until the word is acknowledged.
REQ-020 SHALL, on word_end in S_COLLECT with len==0, ignore it and stay in S_COLLECT.
REQ-021 SHALL, on word_end with len>0, go to S_START next cycle; letter_valid in the same cycle is appended first.
REQ-022 SHALL assert o_WP_dtw_start for exactly one cycle in S_START, then enter S_WAIT and clear the watchdog counter.
REQ-023 SHALL keep o_WP_dtw_word equal to the packed buffer, unused slots zero, stable from S_START until S_DONE exits.
REQ-024 SHALL, in S_WAIT on i_WP_dtw_finish, register i_WP_dtw_result into o_WP_word, keep o_WP_timeout=0, and enter S_DONE.
REQ-025 SHALL, if TIMEOUT_CYC cycles elapse in S_WAIT without finish, copy the packed buffer into o_WP_word, set o_WP_timeout, and enter S_DONE.
REQ-026 SHALL ignore i_WP_dtw_finish outside S_WAIT.
REQ-027 SHALL hold o_WP_word_valid high throughout S_DONE; on i_WP_word_ack, clear buffer, len, overflow and timeout, and return to S_COLLECT next cycle.
REQ-028 SHALL ignore i_WP_word_ack outside S_DONE.

Reset
REQ-029 SHALL, on i_WP_rst_n low, asynchronously force S_COLLECT, buffer=0, len=0, o_WP_word=0, and all 1-bit outputs 0 except o_WP_ready=1.
REQ-030 SHALL, on reset during S_WAIT, abandon the request without issuing another start.

Configuration
REQ-031 SHALL, with WP_DEDUP_EN defined, drop a letter equal to the most recently appended letter of the current word; the first letter is always appended.
REQ-032 SHALL, without WP_DEDUP_EN, append every nonzero valid letter.

Verification
REQ-033 SHALL cover letters 0x11,0x1C then word_end -> one start pulse, dtw_word=120'h1C11, len=2.
REQ-034 SHALL cover DTW finish with result 120'h1C10 -> o_WP_word=120'h1C10, valid=1 until ack, timeout=0, then state=0, len=0.
REQ-035 SHALL cover 17 letters 0x01..0x11 then word_end -> len=15, overflow=1, top slot=0x0F.
REQ-036 SHALL cover no finish for TIMEOUT_CYC=16 -> after 16 cycles in S_WAIT, o_WP_word=packed buffer, timeout=1.
REQ-037 SHALL cover letters 0x05,0x05,0x07 -> len=2, word=120'h0705 with WP_DEDUP_EN defined; len=3, word=120'h070505 without it.
REQ-038 SHALL cover rst_n low in S_WAIT, then a finish pulse -> state=0, valid=0, no start pulse.

Source files
------------

// File: rtl/word_packer.sv
// Word packer: gathers classified letters into a packed word, hands it to the DTW matcher, and holds the answer until acked.
// Optional build macro WP_DEDUP_EN drops a letter equal to the previously appended one.
module word_packer #(
   parameter int LETTER_W    = 8,
   parameter int MAX_LEN     = 15,
   parameter int TIMEOUT_CYC = 65535,
   localparam int W          = LETTER_W * MAX_LEN
) (
   input  logic                i_WP_clk,
   input  logic                i_WP_rst_n,
   input  logic [LETTER_W-1:0] i_WP_letter,
   input  logic                i_WP_letter_valid,
   input  logic                i_WP_word_end,
   output logic                o_WP_ready,
   output logic                o_WP_dtw_start,
   output logic [W-1:0]        o_WP_dtw_word,
   input  logic                i_WP_dtw_finish,
   input  logic [W-1:0]        i_WP_dtw_result,
   output logic [W-1:0]        o_WP_word,
   output logic                o_WP_word_valid,
   input  logic                i_WP_word_ack,
   output logic [3:0]          o_WP_len,
   output logic                o_WP_overflow,
   output logic                o_WP_timeout,
   output logic [1:0]          o_WP_state
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_START   = 2'd1,
      S_WAIT    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           state;
   logic [W-1:0]     buffer;
   logic [3:0]       len;
   logic [CNT_W-1:0] wd_cnt;
   logic             is_dup;
   logic             letter_ok;
   logic             append;
   logic             drop;

`ifdef WP_DEDUP_EN
   logic [LETTER_W-1:0] last_letter;

   always_ff @(posedge i_WP_clk or negedge i_WP_rst_n) begin
      if (!i_WP_rst_n)
         last_letter <= '0;
      else if (append)
         last_letter <= i_WP_letter;
   end

   // last_letter is only meaningful while the word already holds a letter
   always_comb begin
      is_dup = (len != 4'd0) && (i_WP_letter == last_letter);
   end
`else
   always_comb begin
      is_dup = 1'b0;
   end
`endif

   always_comb begin
      letter_ok = (state == S_COLLECT) && i_WP_letter_valid &&
                  (i_WP_letter != '0) && !is_dup;
      append    = letter_ok && (len != LEN_MAX);
      drop      = letter_ok && (len == LEN_MAX);
   end

   // Single FSM; every output is a flop updated together with the state
   always_ff @(posedge i_WP_clk or negedge i_WP_rst_n) begin
      if (!i_WP_rst_n) begin
         state           <= S_COLLECT;
         buffer          <= '0;
         len             <= 4'd0;
         wd_cnt          <= '0;
         o_WP_word       <= '0;
         o_WP_ready      <= 1'b1;
         o_WP_dtw_start  <= 1'b0;
         o_WP_word_valid <= 1'b0;
         o_WP_overflow   <= 1'b0;
         o_WP_timeout    <= 1'b0;
      end else begin
         case (state)
            S_COLLECT: begin
               for (int s = 0; s < MAX_LEN; s++) begin
                  if (append && (len == 4'(s)))
                     buffer[s*LETTER_W +: LETTER_W] <= i_WP_letter;
               end
               if (append)
                  len <= len + 4'd1;
               if (drop)
                  o_WP_overflow <= 1'b1;
               // A letter arriving with word_end counts toward the non-empty test
               if (i_WP_word_end && ((len != 4'd0) || append)) begin
                  state          <= S_START;
                  o_WP_ready     <= 1'b0;
                  o_WP_dtw_start <= 1'b1;
               end
            end
            S_START: begin
               o_WP_dtw_start <= 1'b0;
               wd_cnt         <= '0;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               if (i_WP_dtw_finish) begin
                  o_WP_word       <= i_WP_dtw_result;
                  o_WP_timeout    <= 1'b0;
                  o_WP_word_valid <= 1'b1;
                  state           <= S_DONE;
               end else if (wd_cnt == WD_LAST) begin
                  o_WP_word       <= buffer;
                  o_WP_timeout    <= 1'b1;
                  o_WP_word_valid <= 1'b1;
                  state           <= S_DONE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (i_WP_word_ack) begin
                  buffer          <= '0;
                  len             <= 4'd0;
                  o_WP_overflow   <= 1'b0;
                  o_WP_timeout    <= 1'b0;
                  o_WP_word_valid <= 1'b0;
                  o_WP_ready      <= 1'b1;
                  state           <= S_COLLECT;
               end
            end
            default: state <= S_COLLECT;
         endcase
      end
   end

   assign o_WP_dtw_word = buffer;
   assign o_WP_len      = len;
   assign o_WP_state    = state;

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: table-driven collect/DTW handshake plus directed overflow, timeout, dedup and reset sequences.
// Expectations for the duplicate-letter case follow the WP_DEDUP_EN macro.
module tb_word_packer;

   localparam int LW = 8;
   localparam int ML = 15;
   localparam int W  = LW * ML;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] letter = '0;
   logic          letter_valid = 1'b0;
   logic          word_end = 1'b0;
   logic          ready;
   logic          dtw_start;
   logic [W-1:0]  dtw_word;
   logic          dtw_finish = 1'b0;
   logic [W-1:0]  dtw_result = 120'h1C10;
   logic [W-1:0]  word;
   logic          word_valid;
   logic          word_ack = 1'b0;
   logic [3:0]    len;
   logic          overflow;
   logic          timeout;
   logic [1:0]    state;

   int checks = 0;
   int errors = 0;
   int start_count = 0;

   word_packer #(.LETTER_W(LW), .MAX_LEN(ML), .TIMEOUT_CYC(TO)) dut (
      .i_WP_clk          (clk),
      .i_WP_rst_n        (rst_n),
      .i_WP_letter       (letter),
      .i_WP_letter_valid (letter_valid),
      .i_WP_word_end     (word_end),
      .o_WP_ready        (ready),
      .o_WP_dtw_start    (dtw_start),
      .o_WP_dtw_word     (dtw_word),
      .i_WP_dtw_finish   (dtw_finish),
      .i_WP_dtw_result   (dtw_result),
      .o_WP_word         (word),
      .o_WP_word_valid   (word_valid),
      .i_WP_word_ack     (word_ack),
      .o_WP_len          (len),
      .o_WP_overflow     (overflow),
      .o_WP_timeout      (timeout),
      .o_WP_state        (state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dtw_start)
         start_count++;
   end

   typedef struct {
      logic [LW-1:0] letter;
      logic          valid;
      logic          word_end;
      logic          finish;
      logic          ack;
      logic [1:0]    exp_state;
      logic [3:0]    exp_len;
      logic          exp_start;
      logic          exp_valid;
      logic          exp_ready;
      logic [W-1:0]  exp_dtw_word;
      logic [W-1:0]  exp_word;
   } vec_t;

   vec_t vecs[12];

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      letter       = v.letter;
      letter_valid = v.valid;
      word_end     = v.word_end;
      dtw_finish   = v.finish;
      word_ack     = v.ack;
      @(negedge clk);
      letter_valid = 1'b0;
      word_end     = 1'b0;
      dtw_finish   = 1'b0;
      word_ack     = 1'b0;
   endtask

   task automatic sendLetter(input logic [LW-1:0] l);
      letter       = l;
      letter_valid = 1'b1;
      @(negedge clk);
      letter_valid = 1'b0;
   endtask

   task automatic pulseWordEnd();
      word_end = 1'b1;
      @(negedge clk);
      word_end = 1'b0;
   endtask

   task automatic doReset();
      rst_n        = 1'b0;
      letter_valid = 1'b0;
      word_end     = 1'b0;
      dtw_finish   = 1'b0;
      word_ack     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int            starts_before;
      int            wait_cycles;
      logic          done;
      logic [W-1:0]  exp_full;

      //                letter valid end fin ack  state len  st val rdy dtw_word    word
      vecs[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 120'h0,    120'h0};
      vecs[1]  = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 120'h0,    120'h0};
      vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 120'h0,    120'h0};
      vecs[3]  = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0, 1'b1, 120'h11,   120'h0};
      vecs[4]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 1'b0, 1'b0, 1'b1, 120'h1C11, 120'h0};
      vecs[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 120'h1C11, 120'h0};
      vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 120'h1C11, 120'h0};
      vecs[7]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 120'h1C11, 120'h0};
      vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd2, 1'b0, 1'b1, 1'b0, 120'h1C11, 120'h1C10};
      vecs[9]  = '{8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd2, 1'b0, 1'b1, 1'b0, 120'h1C11, 120'h1C10};
      vecs[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd2, 1'b0, 1'b1, 1'b0, 120'h1C11, 120'h1C10};
      vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 120'h0,    120'h1C10};

      repeat (2) @(negedge clk);
      checkOutput("rst_state", 128'(state), 128'(0));
      checkOutput("rst_ready", 128'(ready), 128'(1));
      checkOutput("rst_start", 128'(dtw_start), 128'(0));
      checkOutput("rst_valid", 128'(word_valid), 128'(0));
      checkOutput("rst_len", 128'(len), 128'(0));
      checkOutput("rst_overflow", 128'(overflow), 128'(0));
      checkOutput("rst_timeout", 128'(timeout), 128'(0));
      checkOutput("rst_word", 128'(word), 128'(0));
      checkOutput("rst_dtw_word", 128'(dtw_word), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] table: collect 0x11,0x1C, DTW finish, ack");
      starts_before = start_count;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_state", i), 128'(state), 128'(vecs[i].exp_state));
         checkOutput($sformatf("v%0d_len", i), 128'(len), 128'(vecs[i].exp_len));
         checkOutput($sformatf("v%0d_start", i), 128'(dtw_start), 128'(vecs[i].exp_start));
         checkOutput($sformatf("v%0d_valid", i), 128'(word_valid), 128'(vecs[i].exp_valid));
         checkOutput($sformatf("v%0d_ready", i), 128'(ready), 128'(vecs[i].exp_ready));
         checkOutput($sformatf("v%0d_dtw_word", i), 128'(dtw_word), 128'(vecs[i].exp_dtw_word));
         checkOutput($sformatf("v%0d_word", i), 128'(word), 128'(vecs[i].exp_word));
         checkOutput($sformatf("v%0d_timeout", i), 128'(timeout), 128'(0));
      end
      checkOutput("one_start_pulse", 128'(start_count - starts_before), 128'(1));

      $display("[TB] overflow: 17 letters then timeout");
      doReset();
      exp_full = '0;
      for (int i = 1; i <= 17; i++) begin
         sendLetter(8'(i));
         if (i <= ML)
            exp_full[(i-1)*LW +: LW] = 8'(i);
      end
      pulseWordEnd();
      checkOutput("ovf_len", 128'(len), 128'(15));
      checkOutput("ovf_flag", 128'(overflow), 128'(1));
      checkOutput("ovf_top_slot", 128'(dtw_word[W-1 -: LW]), 128'(8'h0F));
      checkOutput("ovf_dtw_word", 128'(dtw_word), 128'(exp_full));
      checkOutput("ovf_state_start", 128'(state), 128'(1));
      wait_cycles = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (state == 2'd2)
            wait_cycles++;
         else if (state == 2'd3)
            done = 1'b1;
      end
      checkOutput("to_reached_done", 128'(done), 128'(1));
      checkOutput("to_wait_cycles", 128'(wait_cycles), 128'(TO));
      checkOutput("to_flag", 128'(timeout), 128'(1));
      checkOutput("to_valid", 128'(word_valid), 128'(1));
      checkOutput("to_word", 128'(word), 128'(exp_full));
      checkOutput("to_overflow_held", 128'(overflow), 128'(1));
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
      checkOutput("ack_state", 128'(state), 128'(0));
      checkOutput("ack_overflow", 128'(overflow), 128'(0));
      checkOutput("ack_timeout", 128'(timeout), 128'(0));
      checkOutput("ack_len", 128'(len), 128'(0));

      $display("[TB] duplicate letters 0x05,0x05,0x07");
      doReset();
      sendLetter(8'h05);
      sendLetter(8'h05);
      sendLetter(8'h07);
`ifdef WP_DEDUP_EN
      checkOutput("dup_len", 128'(len), 128'(2));
      checkOutput("dup_word", 128'(dtw_word), 128'(120'h0705));
`else
      checkOutput("dup_len", 128'(len), 128'(3));
      checkOutput("dup_word", 128'(dtw_word), 128'(120'h070505));
`endif

      $display("[TB] reset while waiting for DTW");
      doReset();
      sendLetter(8'h21);
      sendLetter(8'h22);
      pulseWordEnd();
      @(negedge clk);
      checkOutput("rw_in_wait", 128'(state), 128'(2));
      starts_before = start_count;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rw_async_state", 128'(state), 128'(0));
      checkOutput("rw_async_ready", 128'(ready), 128'(1));
      checkOutput("rw_async_len", 128'(len), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dtw_finish = 1'b1;
      @(negedge clk);
      dtw_finish = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rw_no_start", 128'(start_count - starts_before), 128'(0));
      checkOutput("rw_state", 128'(state), 128'(0));
      checkOutput("rw_valid", 128'(word_valid), 128'(0));
      checkOutput("rw_word", 128'(word), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
